// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency MULT/DIV sequencing, HI/LO registers, D-stage stall.
// Optional macro MDU_DIV0_HOLD_EN: divide by zero leaves HI/LO unchanged instead of writing lo=~0, hi=rs.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        md_use_d,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          accept, finish;

   logic [31:0]   op_a, op_b;
   logic          op_div, op_sgn;

   logic          is_md, is_mt;

   logic [63:0]   mul_a, mul_b, product;
   logic          neg_a, neg_b, div_zero;
   logic [31:0]   mag_a, mag_b, divisor, uq, ur, quot, rem;
   logic [31:0]   res_hi, res_lo;
   logic          res_we;

   assign is_md = start & ~op[2];
   assign is_mt = start & (op[2:1] == 2'b10);

   assign busy  = (state == RUN);
   assign stall = md_use_d & (busy | is_md);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (is_md) begin
               accept   = 1'b1;
               state_nx = RUN;
               cnt_nx   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
         end
         RUN: begin
            // result lands on the edge that consumes the last count, so busy spans exactly L cycles
            if (cnt <= CW'(1)) begin
               finish   = 1'b1;
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // zero/sign-extend to 64 bits so one truncated product serves MULT and MULTU
   always_comb begin
      mul_a   = {{32{op_sgn & op_a[31]}}, op_a};
      mul_b   = {{32{op_sgn & op_b[31]}}, op_b};
      product = mul_a * mul_b;
   end

   always_comb begin
      neg_a    = op_sgn & op_a[31];
      neg_b    = op_sgn & op_b[31];
      mag_a    = neg_a ? -op_a : op_a;
      mag_b    = neg_b ? -op_b : op_b;
      div_zero = (op_b == '0);
      divisor  = div_zero ? 32'd1 : mag_b;
      uq       = mag_a / divisor;
      ur       = mag_a % divisor;
      quot     = (neg_a ^ neg_b) ? -uq : uq;
      rem      = neg_a ? -ur : ur;
   end

   always_comb begin
      res_we = 1'b1;
      if (op_div) begin
         res_hi = rem;
         res_lo = quot;
         if (div_zero) begin
`ifdef MDU_DIV0_HOLD_EN
            res_we = 1'b0;
`else
            res_hi = op_a;
            res_lo = '1;
`endif
         end
      end else begin
         res_hi = product[63:32];
         res_lo = product[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_a   <= '0;
         op_b   <= '0;
         op_div <= 1'b0;
         op_sgn <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         if (accept) begin
            op_a   <= rs_val;
            op_b   <= rt_val;
            op_div <= op[1];
            op_sgn <= ~op[0];
         end
         if (finish && res_we) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE && is_mt) begin
            if (op[0]) lo <= rs_val;
            else       hi <= rs_val;
         end
      end
   end

endmodule
